// File: rtl/local_mem_frame_if.sv
// local_mem_frame_if: request/response bundle between the execute/call stages and local_mem_frame.
interface local_mem_frame_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] frame_base;
    logic                  rd_en;
    logic [31:0]           rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_vld;
    logic                  rd_err;
    logic                  we;
    logic [31:0]           wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_err;
    logic                  clr_start;
    logic [ADDR_WIDTH-1:0] clr_base;
    logic [ADDR_WIDTH:0]   clr_len;
    logic                  ready;
    logic                  clr_done;

    modport master (
        output frame_base, rd_en, rd_addr, we, wr_addr, wr_data, clr_start, clr_base, clr_len,
        input  rd_data, rd_vld, rd_err, wr_err, ready, clr_done
    );

    modport slave (
        input  frame_base, rd_en, rd_addr, we, wr_addr, wr_data, clr_start, clr_base, clr_len,
        output rd_data, rd_vld, rd_err, wr_err, ready, clr_done
    );
endinterface

// File: rtl/local_mem_frame.sv
// local_mem_frame: frame-relative WASM locals RAM with bounds checks and a zeroing clear engine.
// Define LOCAL_MEM_BYPASS_EN for write-first forwarding of a same-address read+write.
module local_mem_frame #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 8
) (
    input logic              clk,
    input logic              rst_n,
    local_mem_frame_if.slave bus
);
    localparam int LW = ADDR_WIDTH + 1;
    localparam int CW = ADDR_WIDTH + 2;

    typedef enum logic [1:0] {INIT, IDLE, CLEAR} state_t;

    state_t                state_q, state_d;
    logic [LW-1:0]         cnt_q, cnt_d, len_q, len_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic                  rd_vld_q, rd_vld_d, rd_err_q, rd_err_d, wr_err_q, wr_err_d;
    logic                  clr_done_q, clr_done_d, rd_zero_q, rd_zero_d;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_ram_q;
    logic                  ready, rd_fire, wr_fire, rd_oob, wr_oob, clr_last, mem_we;
    logic [32:0]           rd_phys, wr_phys;
    logic [CW-1:0]         clr_addr;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    assign rd_phys  = 33'(bus.frame_base) + {1'b0, bus.rd_addr};
    assign wr_phys  = 33'(bus.frame_base) + {1'b0, bus.wr_addr};
    assign rd_oob   = rd_phys >= 33'(DEPTH);
    assign wr_oob   = wr_phys >= 33'(DEPTH);
    assign clr_addr = CW'(base_q) + CW'(cnt_q);
    // INIT reuses the clear datapath with base 0 and length DEPTH; a range past the array ends at DEPTH-1
    assign clr_last = (cnt_q == len_q - LW'(1)) || (clr_addr >= CW'(DEPTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            len_q      <= LW'(DEPTH);
            base_q     <= '0;
            rd_vld_q   <= 1'b0;
            rd_err_q   <= 1'b0;
            wr_err_q   <= 1'b0;
            clr_done_q <= 1'b0;
            rd_zero_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            base_q     <= base_d;
            rd_vld_q   <= rd_vld_d;
            rd_err_q   <= rd_err_d;
            wr_err_q   <= wr_err_d;
            clr_done_q <= clr_done_d;
            rd_zero_q  <= rd_zero_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        base_d     = base_q;
        clr_done_d = 1'b0;
        case (state_q)
            IDLE: if (bus.clr_start) begin
                base_d = bus.clr_base;
                len_d  = bus.clr_len;
                cnt_d  = '0;
                if (bus.clr_len == '0) clr_done_d = 1'b1;
                else state_d = CLEAR;
            end
            default: if (clr_last) begin
                state_d    = IDLE;
                cnt_d      = '0;
                clr_done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + LW'(1);
            end
        endcase
    end

    always_comb begin
        ready     = state_q == IDLE;
        rd_fire   = ready && bus.rd_en;
        wr_fire   = ready && bus.we;
        rd_vld_d  = rd_fire;
        rd_err_d  = rd_fire && rd_oob;
        wr_err_d  = wr_fire && wr_oob;
        rd_zero_d = rd_fire ? rd_oob : rd_zero_q;
        mem_we    = ready ? (wr_fire && !wr_oob) : (clr_addr < CW'(DEPTH));
        mem_waddr = ready ? ADDR_WIDTH'(wr_phys) : ADDR_WIDTH'(clr_addr);
        mem_wdata = ready ? bus.wr_data : '0;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        if (rd_fire) rd_ram_q <= mem[ADDR_WIDTH'(rd_phys)];
    end

`ifdef LOCAL_MEM_BYPASS_EN
    logic                  byp_q, byp_d;
    logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d;

    always_comb begin
        byp_d      = rd_fire ? (wr_fire && !wr_oob && wr_phys == rd_phys) : byp_q;
        byp_data_d = rd_fire ? bus.wr_data : byp_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            byp_q      <= byp_d;
            byp_data_q <= byp_data_d;
        end
    end

    assign bus.rd_data = rd_zero_q ? '0 : (byp_q ? byp_data_q : rd_ram_q);
`else
    assign bus.rd_data = rd_zero_q ? '0 : rd_ram_q;
`endif

    assign bus.rd_vld   = rd_vld_q;
    assign bus.rd_err   = rd_err_q;
    assign bus.wr_err   = wr_err_q;
    assign bus.ready    = ready;
    assign bus.clr_done = clr_done_q;
endmodule

// File: tb/tb_local_mem_frame.sv
// tb_local_mem_frame: directed checks of init, frame mapping, bounds, range clear, same-address access and reset abort.
module tb_local_mem_frame;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

`ifdef LOCAL_MEM_BYPASS_EN
    localparam logic [31:0] SAME_EXP = 32'h22;
`else
    localparam logic [31:0] SAME_EXP = 32'h11;
`endif

    always #5 clk = ~clk;

    local_mem_frame_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus ();

    local_mem_frame #(.DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag, input int exp_cycles);
        int n = 0;
        while (!bus.ready && n < 40) begin
            tick();
            n++;
        end
        check({tag, ".cycles"}, 32'(n), 32'(exp_cycles));
        check({tag, ".clr_done"}, 32'(bus.clr_done), 32'd1);
    endtask

    task automatic do_rd(input string tag, input logic [3:0] base, input logic [31:0] idx,
                         input logic [31:0] exp, input logic exp_err);
        bus.frame_base = base;
        bus.rd_addr    = idx;
        bus.rd_en      = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        check({tag, ".vld"}, 32'(bus.rd_vld), 32'd1);
        check({tag, ".data"}, bus.rd_data, exp);
        check({tag, ".err"}, 32'(bus.rd_err), 32'(exp_err));
    endtask

    task automatic do_wr(input string tag, input logic [3:0] base, input logic [31:0] idx,
                         input logic [31:0] data, input logic exp_err);
        bus.frame_base = base;
        bus.wr_addr    = idx;
        bus.wr_data    = data;
        bus.we         = 1'b1;
        tick();
        bus.we = 1'b0;
        check({tag, ".err"}, 32'(bus.wr_err), 32'(exp_err));
    endtask

    initial begin
        int n;
        int gated;
        bus.frame_base = '0;
        bus.rd_en      = 1'b0;
        bus.rd_addr    = '0;
        bus.we         = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.clr_start  = 1'b0;
        bus.clr_base   = '0;
        bus.clr_len    = '0;
        tick();
        tick();
        check("rst.ready", 32'(bus.ready), 32'd0);
        check("rst.rd_vld", 32'(bus.rd_vld), 32'd0);
        check("rst.rd_data", bus.rd_data, 32'd0);
        check("rst.clr_done", 32'(bus.clr_done), 32'd0);
        rst_n = 1'b1;
        wait_ready("init", 16);
        tick();
        check("init.clr_done_pulse", 32'(bus.clr_done), 32'd0);
        for (int i = 0; i < 16; i++) do_rd($sformatf("init_rd%0d", i), 4'd0, 32'(i), 32'd0, 1'b0);

        do_wr("fr_wr", 4'd4, 32'd2, 32'hDEADBEEF, 1'b0);
        do_rd("fr_rd", 4'd0, 32'd6, 32'hDEADBEEF, 1'b0);

        do_wr("oob_wr", 4'd10, 32'd6, 32'h12345678, 1'b1);
        tick();
        check("oob_wr.pulse", 32'(bus.wr_err), 32'd0);
        do_rd("slot0", 4'd0, 32'd0, 32'd0, 1'b0);
        do_wr("s15_wr", 4'd0, 32'd15, 32'h15151515, 1'b0);
        do_rd("b10_rd5", 4'd10, 32'd5, 32'h15151515, 1'b0);
        do_rd("oob_rd", 4'd10, 32'hFFFFFFFF, 32'd0, 1'b1);
        tick();
        check("rd_vld_pulse", 32'(bus.rd_vld), 32'd0);
        check("rd_err_pulse", 32'(bus.rd_err), 32'd0);

        for (int i = 0; i < 16; i++) do_wr($sformatf("fill%0d", i), 4'd0, 32'(i), 32'hA5A5A5A5, 1'b0);
        bus.clr_base  = 4'd12;
        bus.clr_len   = 5'd8;
        bus.clr_start = 1'b1;
        tick();
        bus.clr_start = 1'b0;
        check("clr.ready_low", 32'(bus.ready), 32'd0);
        n     = 0;
        gated = 0;
        bus.frame_base = 4'd0;
        bus.rd_addr    = 32'd1;
        bus.rd_en      = 1'b1;
        while (!bus.ready && n < 40) begin
            tick();
            n++;
            if (bus.rd_vld) gated++;
        end
        bus.rd_en = 1'b0;
        check("clr.busy_cycles", 32'(n), 32'd4);
        check("clr.clr_done", 32'(bus.clr_done), 32'd1);
        check("clr.gated_rd_vld", 32'(gated), 32'd0);
        tick();
        check("clr.clr_done_pulse", 32'(bus.clr_done), 32'd0);
        for (int i = 0; i < 16; i++)
            do_rd($sformatf("clr_rd%0d", i), 4'd0, 32'(i), (i >= 12) ? 32'd0 : 32'hA5A5A5A5, 1'b0);

        bus.clr_base  = 4'd3;
        bus.clr_len   = 5'd0;
        bus.clr_start = 1'b1;
        tick();
        bus.clr_start = 1'b0;
        check("len0.clr_done", 32'(bus.clr_done), 32'd1);
        check("len0.ready", 32'(bus.ready), 32'd1);
        do_rd("len0.slot3", 4'd0, 32'd3, 32'hA5A5A5A5, 1'b0);

        bus.frame_base = 4'd0;
        bus.rd_en      = 1'b1;
        bus.rd_addr    = 32'd5;
        tick();
        check("b2b0.vld", 32'(bus.rd_vld), 32'd1);
        check("b2b0.data", bus.rd_data, 32'hA5A5A5A5);
        bus.rd_addr = 32'd13;
        tick();
        bus.rd_en = 1'b0;
        check("b2b1.vld", 32'(bus.rd_vld), 32'd1);
        check("b2b1.data", bus.rd_data, 32'd0);

        do_wr("same.init", 4'd0, 32'd3, 32'h11, 1'b0);
        bus.frame_base = 4'd0;
        bus.rd_addr    = 32'd3;
        bus.wr_addr    = 32'd3;
        bus.wr_data    = 32'h22;
        bus.rd_en      = 1'b1;
        bus.we         = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        bus.we    = 1'b0;
        check("same.vld", 32'(bus.rd_vld), 32'd1);
        check("same.data", bus.rd_data, SAME_EXP);
        do_rd("same.after", 4'd0, 32'd3, 32'h22, 1'b0);

        bus.clr_base  = 4'd0;
        bus.clr_len   = 5'd10;
        bus.clr_start = 1'b1;
        tick();
        bus.clr_start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("abort.ready", 32'(bus.ready), 32'd0);
        check("abort.rd_data", bus.rd_data, 32'd0);
        check("abort.rd_vld", 32'(bus.rd_vld), 32'd0);
        check("abort.clr_done", 32'(bus.clr_done), 32'd0);
        tick();
        rst_n = 1'b1;
        wait_ready("reinit", 16);
        for (int i = 0; i < 16; i++) do_rd($sformatf("reinit_rd%0d", i), 4'd0, 32'(i), 32'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
